// File: rtl/tau_dip_search_if.sv
// -----------------------------------------------------------------------------
// tau_dip_search_if
//   Handshake and result bundle for the tau_dip_search stage.
//
//   master : upstream/controller side (drives start, average, samples)
//   slave  : the tau_dip_search block itself
//
//   start      frame start request, honoured only while the block is idle
//   average    frame average, captured when start is accepted
//   in_valid   d' sample valid
//   in_data    d'(tau), tau increasing from 0
//   in_ready   sample accepted when in_valid & in_ready
//   busy       frame in progress
//   done       one-cycle result strobe
//   tau_out    selected tau
//   tau_value  d' at the selected tau
//   found      a threshold crossing occurred in this frame
// -----------------------------------------------------------------------------
interface tau_dip_search_if #(
   parameter int DATA_WIDTH = 64,
   parameter int TAU_BITS   = 8
);
   logic                  start;
   logic [DATA_WIDTH-1:0] average;
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic                  busy;
   logic                  done;
   logic [TAU_BITS-1:0]   tau_out;
   logic [DATA_WIDTH-1:0] tau_value;
   logic                  found;

   modport master (
      output start, average, in_valid, in_data,
      input  in_ready, busy, done, tau_out, tau_value, found
   );

   modport slave (
      input  start, average, in_valid, in_data,
      output in_ready, busy, done, tau_out, tau_value, found
   );
endinterface

// File: rtl/tau_dip_search.sv
// -----------------------------------------------------------------------------
// tau_dip_search
//   Streaming min-tau search for the YIN pitch pipeline. Consumes one
//   cumulative-mean-normalised difference d'(tau) per handshake for
//   tau = 0..MAX_TAU-1 and reports the local minimum of the first dip below
//   the absolute threshold (average*THRESH_NUM >> THRESH_SHIFT). Without a
//   crossing it reports the global minimum (FALLBACK_GLOBAL=1) or tau 0.
//   The whole frame is always consumed, so the result appears exactly one
//   cycle after the last sample handshake.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    tau_dip_search_if.slave (start/average, sample stream, result)
// -----------------------------------------------------------------------------
module tau_dip_search #(
   parameter int DATA_WIDTH      = 64,
   parameter int TAU_BITS        = 8,
   parameter int MAX_TAU         = 40,
   parameter int MIN_TAU         = 2,
   parameter int THRESH_NUM      = 13,
   parameter int THRESH_SHIFT    = 7,
   parameter bit FALLBACK_GLOBAL = 1'b1
) (
   input logic             clk,
   input logic             reset,
   tau_dip_search_if.slave bus
);
   localparam int PROD_W = DATA_WIDTH + 16;

   typedef enum logic [2:0] {
      S_IDLE, S_THRESH, S_SCAN, S_DESCEND, S_DRAIN, S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [DATA_WIDTH-1:0] avg_q, thresh_q, thresh_d;
   logic [PROD_W-1:0]     prod, prod_sh;
   logic [TAU_BITS-1:0]   idx_q;
   logic [TAU_BITS-1:0]   gmin_tau_q, gmin_tau_d, cand_tau_q, cand_tau_d, res_tau_q, res_tau_d;
   logic [DATA_WIDTH-1:0] gmin_val_q, gmin_val_d, cand_val_q, cand_val_d, res_val_q, res_val_d;
   logic                  gmin_vld_q, gmin_vld_d, found_q, found_d;
   logic                  ready_c, busy_c, done_c;
   logic                  start_acc, accept, last, qualifies, below_thr, below_cand;

   assign start_acc  = (state_q == S_IDLE) && bus.start;
   assign accept     = bus.in_valid && ready_c;
   assign last       = accept && (int'(idx_q) == MAX_TAU - 1);
   assign qualifies  = int'(idx_q) >= MIN_TAU;
   assign below_thr  = bus.in_data < thresh_q;
   assign below_cand = bus.in_data < cand_val_q;

   // -------------------------------------------------------------- state reg
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // ------------------------------------------------------------- next state
   // NOTE: default assignment first so no path leaves state_d unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (bus.start) state_d = S_THRESH;
         S_THRESH:  state_d = S_SCAN;
         S_SCAN:    if (last)                                state_d = S_DONE;
                    else if (accept && qualifies && below_thr) state_d = S_DESCEND;
         S_DESCEND: if (last)                                state_d = S_DONE;
                    else if (accept && !below_cand)          state_d = S_DRAIN;
         S_DRAIN:   if (last)                                state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      ready_c = 1'b0;
      busy_c  = 1'b0;
      done_c  = 1'b0;
      unique case (state_q)
         S_THRESH:                   busy_c = 1'b1;
         S_SCAN, S_DESCEND, S_DRAIN: begin ready_c = 1'b1; busy_c = 1'b1; end
         S_DONE:                     done_c = 1'b1;
         default: ;
      endcase
   end

   assign bus.in_ready  = ready_c;
   assign bus.busy      = busy_c;
   assign bus.done      = done_c;
   assign bus.tau_out   = res_tau_q;
   assign bus.tau_value = res_val_q;
   assign bus.found     = found_q;

   // -------------------------------------------------------------- threshold
   // THRESH_NUM is at most 16 bits, so the product cannot overflow PROD_W.
   always_comb begin
      prod     = PROD_W'(avg_q) * PROD_W'(THRESH_NUM);
      prod_sh  = prod >> THRESH_SHIFT;
      thresh_d = (|prod_sh[PROD_W-1:DATA_WIDTH]) ? '1 : prod_sh[DATA_WIDTH-1:0];
   end

   // --------------------------------------------------------- search datapath
   // Next values are formed combinationally so the result registers can be
   // loaded on the last handshake with that sample already folded in.
   always_comb begin
      gmin_tau_d = gmin_tau_q;
      gmin_val_d = gmin_val_q;
      gmin_vld_d = gmin_vld_q;
      cand_tau_d = cand_tau_q;
      cand_val_d = cand_val_q;
      found_d    = found_q;
      if (start_acc) begin
         gmin_tau_d = '0;
         gmin_val_d = '0;
         gmin_vld_d = 1'b0;
         cand_tau_d = '0;
         cand_val_d = '0;
         found_d    = 1'b0;
      end else if (accept) begin
         if (state_q == S_SCAN && qualifies) begin
            // Strict compare keeps the earliest index on ties.
            if (!gmin_vld_q || bus.in_data < gmin_val_q) begin
               gmin_tau_d = idx_q;
               gmin_val_d = bus.in_data;
               gmin_vld_d = 1'b1;
            end
            if (below_thr) begin
               cand_tau_d = idx_q;
               cand_val_d = bus.in_data;
               found_d    = 1'b1;
            end
         end else if (state_q == S_DESCEND && below_cand) begin
            cand_tau_d = idx_q;
            cand_val_d = bus.in_data;
         end
      end

      if (found_d) begin
         res_tau_d = cand_tau_d;
         res_val_d = cand_val_d;
      end else if (FALLBACK_GLOBAL) begin
         res_tau_d = gmin_tau_d;
         res_val_d = gmin_val_d;
      end else begin
         res_tau_d = '0;
         res_val_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         avg_q      <= '0;
         thresh_q   <= '0;
         idx_q      <= '0;
         gmin_tau_q <= '0;
         gmin_val_q <= '0;
         gmin_vld_q <= 1'b0;
         cand_tau_q <= '0;
         cand_val_q <= '0;
         found_q    <= 1'b0;
         res_tau_q  <= '0;
         res_val_q  <= '0;
      end else begin
         if (start_acc)              avg_q    <= bus.average;
         if (state_q == S_THRESH)    thresh_q <= thresh_d;
         if (start_acc)              idx_q    <= '0;
         else if (accept)            idx_q    <= idx_q + TAU_BITS'(1);
         gmin_tau_q <= gmin_tau_d;
         gmin_val_q <= gmin_val_d;
         gmin_vld_q <= gmin_vld_d;
         cand_tau_q <= cand_tau_d;
         cand_val_q <= cand_val_d;
         found_q    <= found_d;
         if (last) begin
            res_tau_q <= res_tau_d;
            res_val_q <= res_val_d;
         end
      end
   end
endmodule

// File: tb/tb_tau_dip_search.sv
// -----------------------------------------------------------------------------
// tb_tau_dip_search
//   Two instances share one stimulus stream: dut0 uses the default threshold
//   (13/128) with global fallback, dut1 uses 13/8 (saturates for large
//   averages) with zero fallback. Expected results come from ref_model, which
//   evaluates the selection rules directly on the sample array.
// -----------------------------------------------------------------------------
module tb_tau_dip_search;
   localparam int DW      = 64;
   localparam int TB      = 8;
   localparam int MAX_TAU = 40;
   localparam int MIN_TAU = 2;
   localparam int NUM0    = 13;
   localparam int SH0     = 7;
   localparam int NUM1    = 13;
   localparam int SH1     = 3;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   tau_dip_search_if #(.DATA_WIDTH(DW), .TAU_BITS(TB)) bus0 ();
   tau_dip_search_if #(.DATA_WIDTH(DW), .TAU_BITS(TB)) bus1 ();

   tau_dip_search #(
      .DATA_WIDTH(DW), .TAU_BITS(TB), .MAX_TAU(MAX_TAU), .MIN_TAU(MIN_TAU),
      .THRESH_NUM(NUM0), .THRESH_SHIFT(SH0), .FALLBACK_GLOBAL(1'b1)
   ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

   tau_dip_search #(
      .DATA_WIDTH(DW), .TAU_BITS(TB), .MAX_TAU(MAX_TAU), .MIN_TAU(MIN_TAU),
      .THRESH_NUM(NUM1), .THRESH_SHIFT(SH1), .FALLBACK_GLOBAL(1'b0)
   ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

   assign bus1.start    = bus0.start;
   assign bus1.average  = bus0.average;
   assign bus1.in_valid = bus0.in_valid;
   assign bus1.in_data  = bus0.in_data;

   int          checks      = 0;
   int          failures    = 0;
   int          frames_done = 0;
   int          done_cnt0   = 0;
   int          done_cnt1   = 0;
   logic [63:0] smp [MAX_TAU];

   always @(negedge clk) begin
      if (bus0.done) done_cnt0++;
      if (bus1.done) done_cnt1++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input logic [63:0] v);
      for (int i = 0; i < MAX_TAU; i++) smp[i] = v;
   endtask

   // Selection rules applied to the whole frame at once.
   function automatic void ref_model(input int num, input int shift, input bit fb,
                                     input logic [63:0] avg, output logic [7:0] e_tau,
                                     output logic [63:0] e_val, output logic e_found);
      logic [79:0] p;
      logic [63:0] thr;
      int          first;
      int          j;
      int          g;
      p     = ({16'd0, avg} * 80'(num)) >> shift;
      thr   = (p > 80'({64{1'b1}})) ? {64{1'b1}} : p[63:0];
      first = -1;
      for (int i = MIN_TAU; i < MAX_TAU; i++)
         if (first < 0 && smp[i] < thr) first = i;
      e_tau = 8'd0; e_val = 64'd0; e_found = 1'b0;
      if (first >= 0) begin
         j = first;
         while (j + 1 < MAX_TAU && smp[j+1] < smp[j]) j++;
         e_tau = 8'(j); e_val = smp[j]; e_found = 1'b1;
      end else if (fb) begin
         g = MIN_TAU;
         for (int i = MIN_TAU + 1; i < MAX_TAU; i++)
            if (smp[i] < smp[g]) g = i;
         e_tau = 8'(g); e_val = smp[g];
      end
   endfunction

   // Starts a frame, streams n_send samples with random idle gaps and, for a
   // full frame, checks the result on the cycle after the last handshake.
   // poke_at >= 0 raises start (with a bogus average) while the frame runs.
   task automatic run_frame(input logic [63:0] avg, input int n_send,
                            input int gap_max, input int poke_at);
      logic [7:0]  et0, et1;
      logic [63:0] ev0, ev1;
      logic        ef0, ef1;
      int          waited;
      bit          stalled;
      bit          early_done;
      ref_model(NUM0, SH0, 1'b1, avg, et0, ev0, ef0);
      ref_model(NUM1, SH1, 1'b0, avg, et1, ev1, ef1);
      @(negedge clk);
      bus0.start = 1'b1; bus0.average = avg;
      @(negedge clk);
      bus0.start = 1'b0; bus0.average = ~avg;
      check("thresh_in_ready", bus0.in_ready, 0);
      check("thresh_busy", bus0.busy, 1);
      @(negedge clk);
      check("scan_in_ready", bus0.in_ready, 1);
      stalled = 1'b0; early_done = 1'b0;
      for (int i = 0; i < n_send && !stalled; i++) begin
         repeat ($urandom_range(0, gap_max)) begin
            bus0.in_valid = 1'b0;
            @(negedge clk);
            early_done |= bus0.done | bus1.done;
         end
         if (i == poke_at) bus0.start = 1'b1;
         bus0.in_valid = 1'b1;
         bus0.in_data  = smp[i];
         waited = 0;
         while (!bus0.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
            early_done |= bus0.done | bus1.done;
         end
         if (!bus0.in_ready) stalled = 1'b1;
         else begin
            @(negedge clk);
            bus0.start = 1'b0;
            if (i < MAX_TAU - 1) early_done |= bus0.done | bus1.done;
         end
      end
      bus0.in_valid = 1'b0;
      check("stream_no_stall", stalled, 0);
      check("no_early_done", early_done, 0);
      if (n_send < MAX_TAU) return;
      frames_done++;
      check("done0_after_last", bus0.done, 1);
      check("done1_after_last", bus1.done, 1);
      check("done_in_ready", bus0.in_ready, 0);
      check("done_busy", bus0.busy, 0);
      check("tau_out0", bus0.tau_out, et0);
      check("tau_value0", bus0.tau_value, ev0);
      check("found0", bus0.found, ef0);
      check("tau_out1", bus1.tau_out, et1);
      check("tau_value1", bus1.tau_value, ev1);
      check("found1", bus1.found, ef1);
      @(negedge clk);
      check("done_one_cycle", bus0.done, 0);
      check("idle_in_ready", bus0.in_ready, 0);
      check("hold_tau_out0", bus0.tau_out, et0);
      check("hold_found0", bus0.found, ef0);
   endtask

   task automatic load_test1();
      fill(64'd500);
      smp[5] = 64'd120; smp[6] = 64'd90; smp[7] = 64'd95;
   endtask

   initial begin
      bus0.start = 1'b0; bus0.average = '0; bus0.in_valid = 1'b0; bus0.in_data = '0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", bus0.in_ready, 0);
      check("rst_busy", bus0.busy, 0);
      check("rst_done", bus0.done, 0);
      check("rst_tau_out", bus0.tau_out, 0);
      check("rst_tau_value", bus0.tau_value, 0);
      check("rst_found", bus0.found, 0);
      reset = 1'b1;
      @(negedge clk);

      // First dip below threshold 130: 120, 90, 95 -> local minimum at 6.
      load_test1();
      run_frame(64'd1280, MAX_TAU, 0, -1);

      // No crossing: global minimum, earliest index on ties.
      fill(64'd400); smp[12] = 64'd200; smp[20] = 64'd200;
      run_frame(64'd100, MAX_TAU, 0, -1);

      // Samples below MIN_TAU are ignored.
      fill(64'd500); smp[0] = 64'd0; smp[1] = 64'd0; smp[9] = 64'd50;
      run_frame(64'd1280, MAX_TAU, 0, -1);
      // Equal follow-up sample ends the descent.
      smp[10] = 64'd50;
      run_frame(64'd1280, MAX_TAU, 0, -1);

      // Backpressure gaps plus a start raised mid-frame.
      load_test1();
      run_frame(64'd1280, MAX_TAU, 5, 10);

      // Reset after 17 samples: outputs clear at once, frame abandoned.
      load_test1();
      run_frame(64'd1280, 17, 2, -1);
      reset = 1'b0;
      #1;
      check("abort_in_ready", bus0.in_ready, 0);
      check("abort_busy", bus0.busy, 0);
      check("abort_done", bus0.done, 0);
      check("abort_tau_out", bus0.tau_out, 0);
      check("abort_tau_value", bus0.tau_value, 0);
      check("abort_found", bus0.found, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_no_done0", 64'(done_cnt0), 64'(frames_done));
      for (int i = 0; i < MAX_TAU; i++) smp[i] = 64'($urandom_range(0, 3000));
      run_frame(64'd9000, MAX_TAU, 1, -1);

      // Huge average: every qualifying sample crosses; rising stream -> tau 2.
      for (int i = 0; i < MAX_TAU; i++) smp[i] = 64'(i * 3 + 1);
      run_frame({64{1'b1}}, MAX_TAU, 0, -1);

      // Dip still descending at the last sample.
      fill(64'd500);
      smp[35] = 64'd100; smp[36] = 64'd90; smp[37] = 64'd80; smp[38] = 64'd70; smp[39] = 64'd60;
      run_frame(64'd1280, MAX_TAU, 0, -1);

      // Random frames.
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < MAX_TAU; i++) smp[i] = 64'($urandom_range(0, 3000));
         run_frame(64'($urandom_range(0, 20000)), MAX_TAU, 3, -1);
      end

      repeat (2) @(negedge clk);
      check("done_count0", 64'(done_cnt0), 64'(frames_done));
      check("done_count1", 64'(done_cnt1), 64'(frames_done));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
